// File: rtl/jtpopeye_pkg.sv
// rtl/jtpopeye_pkg.sv - state encoding, region indices and default ROM map for the Popeye loader
package jtpopeye_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERR    = 3'd4
   } state_e;

   localparam int REG_MAIN = 0;
   localparam int REG_CHAR = 1;
   localparam int REG_SPR  = 2;
   localparam int REG_PROM = 3;

   // Default image layout, also used by jtpopeye_game for its bank sizes
   localparam logic [21:0] DEF_REG1_START = 22'h08000;
   localparam logic [21:0] DEF_REG2_START = 22'h09000;
   localparam logic [21:0] DEF_REG3_START = 22'h11000;
   localparam logic [21:0] DEF_ROM_SIZE   = 22'h11340;
   localparam int          DEF_SETTLE     = 16;

endpackage

// File: rtl/jtpopeye_romload_dec.sv
// rtl/jtpopeye_romload_dec.sv - maps an image byte address to a one-hot ROM region and region offset
module jtpopeye_romload_dec
   import jtpopeye_pkg::*;
#(
   parameter logic [21:0] REG1_START = DEF_REG1_START,
   parameter logic [21:0] REG2_START = DEF_REG2_START,
   parameter logic [21:0] REG3_START = DEF_REG3_START
)(
   input  logic [21:0] addr,
   output logic [3:0]  sel,
   output logic [21:0] offset
);

   always_comb begin
      sel    = '0;
      offset = addr;
      if (addr >= REG3_START) begin
         sel[REG_PROM] = 1'b1;
         offset        = addr - REG3_START;
      end else if (addr >= REG2_START) begin
         sel[REG_SPR] = 1'b1;
         offset       = addr - REG2_START;
      end else if (addr >= REG1_START) begin
         sel[REG_CHAR] = 1'b1;
         offset        = addr - REG1_START;
      end else begin
         sel[REG_MAIN] = 1'b1;
      end
   end

endmodule

// File: rtl/jtpopeye_romload.sv
// rtl/jtpopeye_romload.sv - ioctl download sequencer: region strobes, size check, game reset and rom_ok
// Optional JTPOPEYE_ROMCHK_EN adds a 16-bit byte checksum (chk_sum) compared against ROM_CHK.
module jtpopeye_romload
   import jtpopeye_pkg::*;
#(
   parameter logic [21:0] REG1_START = DEF_REG1_START,
   parameter logic [21:0] REG2_START = DEF_REG2_START,
   parameter logic [21:0] REG3_START = DEF_REG3_START,
   parameter logic [21:0] ROM_SIZE   = DEF_ROM_SIZE,
   parameter int          SETTLE     = DEF_SETTLE
`ifdef JTPOPEYE_ROMCHK_EN
   , parameter logic [15:0] ROM_CHK  = 16'h0000
`endif
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        downloading,
   input  logic [21:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   input  logic        ioctl_wr,
   output logic [21:0] prog_addr,
   output logic [7:0]  prog_data,
   output logic [3:0]  prog_we,
   output logic        game_rst,
   output logic        rom_ok,
   output logic        load_err,
   output logic [21:0] byte_cnt
`ifdef JTPOPEYE_ROMCHK_EN
   , output logic [15:0] chk_sum
`endif
);

   state_e      state;
   logic [15:0] settle_cnt;
   logic        range_err;

   logic [3:0]  dec_sel;
   logic [21:0] dec_off;
   logic        in_load;
   logic        accept;
   logic        out_of_range;
   logic        range_next;
   logic [21:0] cnt_next;
   logic        load_good;
   logic        start;

   jtpopeye_romload_dec #(
      .REG1_START (REG1_START),
      .REG2_START (REG2_START),
      .REG3_START (REG3_START)
   ) u_dec (
      .addr   (ioctl_addr),
      .sel    (dec_sel),
      .offset (dec_off)
   );

   assign in_load      = (state == ST_LOAD);
   assign accept       = in_load && ioctl_wr && (ioctl_addr < ROM_SIZE);
   assign out_of_range = in_load && ioctl_wr && !(ioctl_addr < ROM_SIZE);
   assign range_next   = range_err | out_of_range;
   assign cnt_next     = (accept && byte_cnt != 22'h3FFFFF) ? byte_cnt + 22'd1 : byte_cnt;
   assign start        = downloading && !in_load;

   // A byte arriving in the same cycle downloading drops must be part of the final verdict
`ifdef JTPOPEYE_ROMCHK_EN
   logic [15:0] chk_next;
   assign chk_next  = accept ? chk_sum + {8'h00, ioctl_data} : chk_sum;
   assign load_good = !range_next && (cnt_next == ROM_SIZE) &&
                      ((ROM_CHK == 16'h0000) || (chk_next == ROM_CHK));
`else
   assign load_good = !range_next && (cnt_next == ROM_SIZE);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         range_err  <= 1'b0;
         prog_we    <= '0;
         prog_addr  <= '0;
         prog_data  <= '0;
         byte_cnt   <= '0;
         game_rst   <= 1'b1;
         rom_ok     <= 1'b0;
         load_err   <= 1'b0;
`ifdef JTPOPEYE_ROMCHK_EN
         chk_sum    <= '0;
`endif
      end else begin
         prog_we <= accept ? dec_sel : 4'b0000;
         if (accept) begin
            prog_addr <= dec_off;
            prog_data <= ioctl_data;
         end
         case (state)
            ST_LOAD: begin
               byte_cnt  <= cnt_next;
               range_err <= range_next;
`ifdef JTPOPEYE_ROMCHK_EN
               chk_sum   <= chk_next;
`endif
               if (!downloading) begin
                  if (load_good) begin
                     state      <= ST_SETTLE;
                     settle_cnt <= 16'(SETTLE - 1);
                  end else begin
                     state    <= ST_ERR;
                     load_err <= 1'b1;
                  end
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == 16'd0) begin
                  state    <= ST_DONE;
                  game_rst <= 1'b0;
                  rom_ok   <= 1'b1;
               end else begin
                  settle_cnt <= settle_cnt - 16'd1;
               end
            end
            default: ;
         endcase
         // New download from any idle-ish state, including mid-settle, restarts cleanly
         if (start) begin
            state      <= ST_LOAD;
            settle_cnt <= '0;
            byte_cnt   <= '0;
            range_err  <= 1'b0;
            load_err   <= 1'b0;
            rom_ok     <= 1'b0;
            game_rst   <= 1'b1;
`ifdef JTPOPEYE_ROMCHK_EN
            chk_sum    <= '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_jtpopeye_romload.sv
// tb/tb_jtpopeye_romload.sv - scoreboard bench for jtpopeye_romload on a scaled-down image map
// Optional JTPOPEYE_ROMCHK_EN section exercises the checksum pass/fail paths.
module tb_jtpopeye_romload;
   import jtpopeye_pkg::*;

   localparam logic [21:0] R1 = 22'h080;
   localparam logic [21:0] R2 = 22'h090;
   localparam logic [21:0] R3 = 22'h110;
   localparam logic [21:0] SZ = 22'h134;

   int tests = 0;
   int fails = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        downloading;
   logic [21:0] ioctl_addr;
   logic [7:0]  ioctl_data;
   logic        ioctl_wr;
   logic [21:0] prog_addr;
   logic [7:0]  prog_data;
   logic [3:0]  prog_we;
   logic        game_rst;
   logic        rom_ok;
   logic        load_err;
   logic [21:0] byte_cnt;
`ifdef JTPOPEYE_ROMCHK_EN
   logic [15:0] chk_sum;
`endif

   always #5 clk = ~clk;

   jtpopeye_romload #(
      .REG1_START (R1),
      .REG2_START (R2),
      .REG3_START (R3),
      .ROM_SIZE   (SZ),
      .SETTLE     (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .ioctl_addr  (ioctl_addr),
      .ioctl_data  (ioctl_data),
      .ioctl_wr    (ioctl_wr),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .prog_we     (prog_we),
      .game_rst    (game_rst),
      .rom_ok      (rom_ok),
      .load_err    (load_err),
      .byte_cnt    (byte_cnt)
`ifdef JTPOPEYE_ROMCHK_EN
      , .chk_sum   (chk_sum)
`endif
   );

   logic [3:0]  ref_sel;
   logic [21:0] ref_off;

   jtpopeye_romload_dec #(
      .REG1_START (R1),
      .REG2_START (R2),
      .REG3_START (R3)
   ) u_ref (
      .addr   (ioctl_addr),
      .sel    (ref_sel),
      .offset (ref_off)
   );

   typedef struct packed {
      logic [3:0]  we;
      logic [21:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t sbq[$];
   int   we_cnt[4];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (prog_we != 4'b0000) begin
         for (int i = 0; i < 4; i++)
            if (prog_we[i]) we_cnt[i]++;
         if (sbq.size() == 0) begin
            check("unexpected_strobe", {28'h0, prog_we}, 32'h0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("strobe_we", {28'h0, prog_we}, {28'h0, e.we});
            check("strobe_addr", {10'h0, prog_addr}, {10'h0, e.addr});
            check("strobe_data", {24'h0, prog_data}, {24'h0, e.data});
         end
      end
   end

   task automatic send(input logic [21:0] a, input logic [7:0] d);
      @(negedge clk);
      ioctl_addr = a;
      ioctl_data = d;
      ioctl_wr   = 1'b1;
      #1;
      if (a < SZ) sbq.push_back('{we: ref_sel, addr: ref_off, data: d});
      @(negedge clk);
      ioctl_wr = 1'b0;
   endtask

   task automatic start_load();
      @(negedge clk);
      downloading = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) we_cnt[i] = 0;
      check("start_game_rst", {31'h0, game_rst}, 32'h1);
      check("start_rom_ok", {31'h0, rom_ok}, 32'h0);
      check("start_byte_cnt", {10'h0, byte_cnt}, 32'h0);
   endtask

   task automatic run_load(input int n, input int gap, input bit extra_oor);
      start_load();
      for (int a = 0; a < n; a++) begin
         send(22'(a), 8'(a));
         if (22'(a) == R1) begin
            check("bound_we", {28'h0, prog_we}, 32'h2);
            check("bound_addr", {10'h0, prog_addr}, 32'h0);
         end
         repeat (gap) @(negedge clk);
      end
      if (extra_oor) send(SZ, 8'h5A);
      downloading = 1'b0;
   endtask

   task automatic wait_settle(input int exp_n);
      int n = 0;
      @(negedge clk);
      while (game_rst && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("settle_cycles", n, exp_n);
   endtask

   task automatic check_counts(input int c0, input int c1, input int c2, input int c3);
      check("cnt_main", we_cnt[0], c0);
      check("cnt_char", we_cnt[1], c1);
      check("cnt_spr", we_cnt[2], c2);
      check("cnt_prom", we_cnt[3], c3);
   endtask

`ifdef JTPOPEYE_ROMCHK_EN
   logic        c_dl;
   logic [21:0] c_addr;
   logic [7:0]  c_data;
   logic        c_wr;
   logic [21:0] c_paddr[2];
   logic [7:0]  c_pdata[2];
   logic [3:0]  c_pwe[2];
   logic        c_grst[2];
   logic        c_ok[2];
   logic        c_err[2];
   logic [21:0] c_cnt[2];
   logic [15:0] c_sum[2];

   jtpopeye_romload #(.REG1_START(22'd1), .REG2_START(22'd2), .REG3_START(22'd3),
      .ROM_SIZE(22'd4), .SETTLE(16), .ROM_CHK(16'h01FF)) u_chk_ok (
      .clk(clk), .rst(rst), .downloading(c_dl), .ioctl_addr(c_addr), .ioctl_data(c_data),
      .ioctl_wr(c_wr), .prog_addr(c_paddr[0]), .prog_data(c_pdata[0]), .prog_we(c_pwe[0]),
      .game_rst(c_grst[0]), .rom_ok(c_ok[0]), .load_err(c_err[0]), .byte_cnt(c_cnt[0]),
      .chk_sum(c_sum[0]));

   jtpopeye_romload #(.REG1_START(22'd1), .REG2_START(22'd2), .REG3_START(22'd3),
      .ROM_SIZE(22'd4), .SETTLE(16), .ROM_CHK(16'h0200)) u_chk_bad (
      .clk(clk), .rst(rst), .downloading(c_dl), .ioctl_addr(c_addr), .ioctl_data(c_data),
      .ioctl_wr(c_wr), .prog_addr(c_paddr[1]), .prog_data(c_pdata[1]), .prog_we(c_pwe[1]),
      .game_rst(c_grst[1]), .rom_ok(c_ok[1]), .load_err(c_err[1]), .byte_cnt(c_cnt[1]),
      .chk_sum(c_sum[1]));

   task automatic chk_test();
      logic [7:0] img[4];
      img[0] = 8'hFF; img[1] = 8'hFF; img[2] = 8'h01; img[3] = 8'h00;
      @(negedge clk);
      c_dl = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         c_addr = 22'(i);
         c_data = img[i];
         c_wr   = 1'b1;
      end
      @(negedge clk);
      c_wr = 1'b0;
      c_dl = 1'b0;
      repeat (25) @(negedge clk);
      check("chk_sum", {16'h0, c_sum[0]}, 32'h01FF);
      check("chk_match_ok", {31'h0, c_ok[0]}, 32'h1);
      check("chk_match_grst", {31'h0, c_grst[0]}, 32'h0);
      check("chk_mismatch_err", {31'h0, c_err[1]}, 32'h1);
      check("chk_mismatch_ok", {31'h0, c_ok[1]}, 32'h0);
   endtask
`endif

   initial begin
      rst         = 1'b1;
      downloading = 1'b0;
      ioctl_addr  = '0;
      ioctl_data  = '0;
      ioctl_wr    = 1'b0;
`ifdef JTPOPEYE_ROMCHK_EN
      c_dl = 1'b0; c_addr = '0; c_data = '0; c_wr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_prog_we", {28'h0, prog_we}, 32'h0);
      check("rst_prog_addr", {10'h0, prog_addr}, 32'h0);
      check("rst_prog_data", {24'h0, prog_data}, 32'h0);
      check("rst_byte_cnt", {10'h0, byte_cnt}, 32'h0);
      check("rst_game_rst", {31'h0, game_rst}, 32'h1);
      check("rst_rom_ok", {31'h0, rom_ok}, 32'h0);
      check("rst_load_err", {31'h0, load_err}, 32'h0);
      check("rst_state", {29'h0, dut.state}, {29'h0, ST_IDLE});
      rst = 1'b0;

      // Full load, one byte every four cycles
      run_load(int'(SZ), 2, 1'b0);
      wait_settle(16);
      check("full_rom_ok", {31'h0, rom_ok}, 32'h1);
      check("full_load_err", {31'h0, load_err}, 32'h0);
      check("full_byte_cnt", {10'h0, byte_cnt}, {10'h0, SZ});
      check_counts(128, 16, 128, 36);

      // Short load stops at the PROM region start
      run_load(int'(R3), 0, 1'b0);
      repeat (20) @(negedge clk);
      check("short_load_err", {31'h0, load_err}, 32'h1);
      check("short_game_rst", {31'h0, game_rst}, 32'h1);
      check("short_rom_ok", {31'h0, rom_ok}, 32'h0);
      check("short_byte_cnt", {10'h0, byte_cnt}, 32'h110);

      // Full image followed by one byte past the end
      run_load(int'(SZ), 0, 1'b1);
      repeat (20) @(negedge clk);
      check_counts(128, 16, 128, 36);
      check("oor_byte_cnt", {10'h0, byte_cnt}, {10'h0, SZ});
      check("oor_load_err", {31'h0, load_err}, 32'h1);
      check("oor_rom_ok", {31'h0, rom_ok}, 32'h0);

      // Back-to-back writes across the main/char boundary
      start_load();
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i > 0) check("b2b_we", {28'h0, prog_we}, (i <= 4) ? 32'h1 : 32'h2);
         if (i < 8) begin
            ioctl_addr = 22'h07C + 22'(i);
            ioctl_data = 8'hA0 + 8'(i);
            ioctl_wr   = 1'b1;
            #1;
            sbq.push_back('{we: ref_sel, addr: ref_off, data: ioctl_data});
         end else begin
            ioctl_wr = 1'b0;
         end
      end
      check("b2b_byte_cnt", {10'h0, byte_cnt}, 32'h8);
      downloading = 1'b0;
      repeat (3) @(negedge clk);
      check("b2b_load_err", {31'h0, load_err}, 32'h1);

      // New download arrives while settling
      run_load(int'(SZ), 0, 1'b0);
      repeat (11) @(negedge clk);
      check("settle_cnt_5", {16'h0, dut.settle_cnt}, 32'h5);
      downloading = 1'b1;
      @(negedge clk);
      check("resettle_state", {29'h0, dut.state}, {29'h0, ST_LOAD});
      check("resettle_game_rst", {31'h0, game_rst}, 32'h1);
      check("resettle_byte_cnt", {10'h0, byte_cnt}, 32'h0);

      // Reset in the middle of a load, coinciding with a byte write
      for (int a = 0; a < 10; a++) send(22'(a), 8'(a));
      @(negedge clk);
      ioctl_addr  = 22'd10;
      ioctl_data  = 8'h33;
      ioctl_wr    = 1'b1;
      rst         = 1'b1;
      downloading = 1'b0;
      @(negedge clk);
      check("midrst_prog_we", {28'h0, prog_we}, 32'h0);
      check("midrst_byte_cnt", {10'h0, byte_cnt}, 32'h0);
      check("midrst_state", {29'h0, dut.state}, {29'h0, ST_IDLE});
      check("midrst_game_rst", {31'h0, game_rst}, 32'h1);
      ioctl_wr = 1'b0;
      rst      = 1'b0;

      // Load after reset is clean
      run_load(int'(SZ), 0, 1'b0);
      wait_settle(16);
      check("clean_rom_ok", {31'h0, rom_ok}, 32'h1);
      check("clean_byte_cnt", {10'h0, byte_cnt}, {10'h0, SZ});
      check_counts(128, 16, 128, 36);

`ifdef JTPOPEYE_ROMCHK_EN
      chk_test();
`endif

      repeat (2) @(negedge clk);
      check("sb_empty", sbq.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
